// File: rtl/closest_hit_sched.sv
// rtl/closest_hit_sched.sv - closest-hit scheduler for one ray against a contiguous triangle list
module closest_hit_sched #(
    parameter int ADDR_W  = 16,
    parameter int MEM_LAT = 1
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              i_start,
    input  logic [191:0]      i_ray,
    input  logic [ADDR_W-1:0] i_base,
    input  logic [ADDR_W-1:0] i_num_tris,
    input  logic              i_abort,
    output logic              o_ready,
    output logic              o_tri_rd,
    output logic [ADDR_W-1:0] o_tri_addr,
    input  logic [287:0]      i_tri_data,
    output logic              o_isect_en,
    output logic [287:0]      o_isect_tri,
    output logic [191:0]      o_isect_ray,
    input  logic              i_isect_valid,
    input  logic              i_isect_result,
    input  logic [31:0]       i_isect_t,
    output logic              o_valid,
    output logic              o_hit,
    output logic [31:0]       o_t,
    output logic [ADDR_W-1:0] o_tri_idx
);

    localparam logic [31:0] T_MAX = 32'h7FFF_FFFF;

    typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, DONE, FLUSH} state_t;

    state_t              state;
    logic [ADDR_W-1:0]   num_tris;
    logic [ADDR_W-1:0]   issue_cnt;
    logic [ADDR_W-1:0]   ret_cnt;
    logic [31:0]         best_t;
    logic [ADDR_W-1:0]   best_idx;
    logic                best_hit;
    logic [MEM_LAT-1:0]  rd_pipe;

    logic                take;
    logic                better;
    logic [ADDR_W-1:0]   ret_nxt;
    logic [31:0]         best_t_nxt;
    logic [ADDR_W-1:0]   best_idx_nxt;
    logic                best_hit_nxt;
    logic [MEM_LAT:0]    rd_shift;

    // Results arriving while flushing only advance the return count; they never touch best.
    always_comb begin
        take         = i_isect_valid && (state == ISSUE || state == DRAIN || state == FLUSH);
        better       = take && (state != FLUSH) && i_isect_result &&
                       ($signed(i_isect_t) < $signed(best_t));
        ret_nxt      = ret_cnt + ADDR_W'(take);
        best_t_nxt   = better ? i_isect_t : best_t;
        best_idx_nxt = better ? ret_cnt : best_idx;
        best_hit_nxt = better | best_hit;
        rd_shift     = {rd_pipe, o_tri_rd};
    end

    assign o_isect_en  = rd_pipe[MEM_LAT-1];
    assign o_isect_tri = i_tri_data;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state       <= IDLE;
            num_tris    <= '0;
            issue_cnt   <= '0;
            ret_cnt     <= '0;
            best_t      <= T_MAX;
            best_idx    <= '0;
            best_hit    <= 1'b0;
            rd_pipe     <= '0;
            o_ready     <= 1'b1;
            o_tri_rd    <= 1'b0;
            o_tri_addr  <= '0;
            o_isect_ray <= '0;
            o_valid     <= 1'b0;
            o_hit       <= 1'b0;
            o_t         <= T_MAX;
            o_tri_idx   <= '0;
        end else begin
            rd_pipe  <= rd_shift[MEM_LAT-1:0];
            ret_cnt  <= ret_nxt;
            best_t   <= best_t_nxt;
            best_idx <= best_idx_nxt;
            best_hit <= best_hit_nxt;
            o_valid  <= 1'b0;
            if (i_abort && state != IDLE) begin
                // A read on the bus this cycle is already committed and will return a result.
                state     <= FLUSH;
                o_tri_rd  <= 1'b0;
                o_ready   <= 1'b0;
                issue_cnt <= issue_cnt + ADDR_W'(o_tri_rd);
            end else begin
                case (state)
                    IDLE: begin
                        if (i_start) begin
                            o_isect_ray <= i_ray;
                            num_tris    <= i_num_tris;
                            issue_cnt   <= '0;
                            ret_cnt     <= '0;
                            best_t      <= T_MAX;
                            best_idx    <= '0;
                            best_hit    <= 1'b0;
                            o_hit       <= 1'b0;
                            o_t         <= T_MAX;
                            o_tri_idx   <= '0;
                            o_ready     <= 1'b0;
                            if (i_num_tris == '0) begin
                                state   <= DONE;
                                o_valid <= 1'b1;
                            end else begin
                                state      <= ISSUE;
                                o_tri_rd   <= 1'b1;
                                o_tri_addr <= i_base;
                            end
                        end
                    end
                    ISSUE: begin
                        issue_cnt <= issue_cnt + ADDR_W'(1);
                        if (issue_cnt + ADDR_W'(1) == num_tris) begin
                            o_tri_rd <= 1'b0;
                            state    <= DRAIN;
                        end else begin
                            o_tri_addr <= o_tri_addr + ADDR_W'(1);
                        end
                    end
                    DRAIN: begin
                        if (ret_nxt == num_tris) begin
                            state     <= DONE;
                            o_valid   <= 1'b1;
                            o_hit     <= best_hit_nxt;
                            o_t       <= best_t_nxt;
                            o_tri_idx <= best_idx_nxt;
                        end
                    end
                    DONE: begin
                        state   <= IDLE;
                        o_ready <= 1'b1;
                    end
                    FLUSH: begin
                        if (ret_nxt == issue_cnt) begin
                            state   <= IDLE;
                            o_ready <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_closest_hit_sched.sv
// tb/tb_closest_hit_sched.sv - scoreboard bench for closest_hit_sched with memory and 2-cycle intersection models
module tb_closest_hit_sched;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_start = 1'b0;
    logic [191:0]  i_ray = '0;
    logic [15:0]   i_base = '0;
    logic [15:0]   i_num_tris = '0;
    logic          i_abort = 1'b0;
    logic          o_ready;
    logic          o_tri_rd;
    logic [15:0]   o_tri_addr;
    logic [287:0]  i_tri_data = '0;
    logic          o_isect_en;
    logic [287:0]  o_isect_tri;
    logic [191:0]  o_isect_ray;
    logic          i_isect_valid = 1'b0;
    logic          i_isect_result = 1'b0;
    logic [31:0]   i_isect_t = '0;
    logic          o_valid;
    logic          o_hit;
    logic [31:0]   o_t;
    logic [15:0]   o_tri_idx;

    int checks = 0;
    int errors = 0;

    logic [15:0]   addr_q[$];
    logic [48:0]   res_q[$];
    logic          res_tab[16];
    logic [31:0]   t_tab[16];
    int            en_idx = 0;
    int            p_i = 0;
    logic          p_v = 1'b0;
    int            ret_seen = 0;

    closest_hit_sched #(.ADDR_W(16), .MEM_LAT(1)) dut (
        .i_clk(clk), .i_rstn(rst_n), .i_start(i_start), .i_ray(i_ray), .i_base(i_base),
        .i_num_tris(i_num_tris), .i_abort(i_abort), .o_ready(o_ready), .o_tri_rd(o_tri_rd),
        .o_tri_addr(o_tri_addr), .i_tri_data(i_tri_data), .o_isect_en(o_isect_en),
        .o_isect_tri(o_isect_tri), .o_isect_ray(o_isect_ray), .i_isect_valid(i_isect_valid),
        .i_isect_result(i_isect_result), .i_isect_t(i_isect_t), .o_valid(o_valid), .o_hit(o_hit),
        .o_t(o_t), .o_tri_idx(o_tri_idx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Triangle memory: one-cycle read latency, data tagged with the address.
    always @(posedge clk) i_tri_data <= {9{{16'h0, o_tri_addr}}};

    // Intersection unit: results two cycles after enable, looked up by issue order.
    always @(posedge clk) begin
        if (i_start && o_ready) en_idx <= 0;
        else if (o_isect_en) en_idx <= en_idx + 1;
        p_v <= o_isect_en;
        p_i <= en_idx;
        i_isect_valid  <= p_v;
        i_isect_result <= p_v ? res_tab[p_i % 16] : 1'b0;
        i_isect_t      <= p_v ? t_tab[p_i % 16] : 32'h0;
        if (p_v) ret_seen <= ret_seen + 1;
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (o_tri_rd) begin
                if (addr_q.size() == 0) chk("unexpected_read", {48'h0, o_tri_addr}, 64'hFFFF_FFFF);
                else chk("tri_addr", {48'h0, o_tri_addr}, {48'h0, addr_q.pop_front()});
            end
            if (o_valid) begin
                if (res_q.size() == 0) begin
                    chk("unexpected_valid", 64'h1, 64'h0);
                end else begin
                    logic [48:0] e;
                    e = res_q.pop_front();
                    chk("hit", {63'h0, o_hit}, {63'h0, e[48]});
                    chk("t", {32'h0, o_t}, {32'h0, e[47:16]});
                    chk("tri_idx", {48'h0, o_tri_idx}, {48'h0, e[15:0]});
                end
            end
        end
    end

    task automatic set_tab(input int i, input logic r, input logic [31:0] t);
        res_tab[i] = r;
        t_tab[i]   = t;
    endtask

    task automatic run_ray(input logic [15:0] base, input logic [15:0] n, input int exp_lat,
                           input logic busy_start);
        int lat;
        logic [191:0] ray;
        ray = {6{$urandom()}};
        @(posedge clk); #1;
        i_ray = ray; i_base = base; i_num_tris = n; i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        chk("isect_ray", {63'h0, o_isect_ray != ray}, 64'h0);
        if (busy_start) begin
            @(posedge clk); #1;
            i_base = 16'h1234; i_num_tris = 16'd5; i_start = 1'b1;
            @(posedge clk); #1;
            i_start = 1'b0;
        end
        lat = 0;
        while (lat < 200) begin
            @(negedge clk);
            lat++;
            if (o_valid) break;
        end
        if (!o_valid) chk("valid_timeout", 64'h0, 64'h1);
        else if (exp_lat > 0) chk("latency", 64'(lat), 64'(exp_lat));
        @(negedge clk);
        chk("ready_after_done", {63'h0, o_ready}, 64'h1);
    endtask

    initial begin
        int ret0;
        int w;
        for (int i = 0; i < 16; i++) set_tab(i, 1'b0, 32'h0);
        repeat (10) @(negedge clk);
        chk("rst_ready", {63'h0, o_ready}, 64'h1);
        chk("rst_valid", {63'h0, o_valid}, 64'h0);
        chk("rst_t", {32'h0, o_t}, 64'h7FFF_FFFF);
        chk("rst_tri_rd", {63'h0, o_tri_rd}, 64'h0);
        chk("rst_tri_idx", {48'h0, o_tri_idx}, 64'h0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Only index 1 hits.
        set_tab(0, 1'b0, 32'h5000); set_tab(1, 1'b1, 32'h10000); set_tab(2, 1'b0, 32'h3000);
        for (int i = 0; i < 3; i++) addr_q.push_back(16'h0010 + 16'(i));
        res_q.push_back({1'b1, 32'h10000, 16'd1});
        run_ray(16'h0010, 16'd3, 7, 1'b0);

        // All hit, tie between 1 and 2 keeps 1.
        set_tab(0, 1'b1, 32'h2C000); set_tab(1, 1'b1, 32'h10000); set_tab(2, 1'b1, 32'h10000);
        for (int i = 0; i < 3; i++) addr_q.push_back(16'h0200 + 16'(i));
        res_q.push_back({1'b1, 32'h10000, 16'd1});
        run_ray(16'h0200, 16'd3, 7, 1'b0);

        // Empty list: no reads, immediate miss.
        res_q.push_back({1'b0, 32'h7FFF_FFFF, 16'd0});
        run_ray(16'h0300, 16'd0, 1, 1'b0);

        // Abort after the third read of eight.
        for (int i = 0; i < 8; i++) set_tab(i, 1'b1, 32'h100 + 32'(i));
        for (int i = 0; i < 3; i++) addr_q.push_back(16'h0100 + 16'(i));
        ret0 = ret_seen;
        @(posedge clk); #1;
        i_base = 16'h0100; i_num_tris = 16'd8; i_start = 1'b1;
        @(posedge clk); #1 i_start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1 i_abort = 1'b1;
        @(posedge clk); #1 i_abort = 1'b0;
        w = 0;
        while (w < 30) begin
            @(negedge clk);
            w++;
            if (o_ready) break;
        end
        chk("abort_ready", {63'h0, o_ready}, 64'h1);
        chk("abort_returns", 64'(ret_seen - ret0), 64'd3);
        repeat (5) @(negedge clk);

        // Address wrap, signed compare, miss ignored, second start while busy ignored.
        set_tab(0, 1'b1, 32'h30000); set_tab(1, 1'b0, 32'h00001);
        set_tab(2, 1'b1, 32'hFFFF_0000); set_tab(3, 1'b1, 32'h8000);
        addr_q.push_back(16'hFFFE); addr_q.push_back(16'hFFFF);
        addr_q.push_back(16'h0000); addr_q.push_back(16'h0001);
        res_q.push_back({1'b1, 32'hFFFF_0000, 16'd2});
        run_ray(16'hFFFE, 16'd4, 0, 1'b1);

        repeat (10) @(negedge clk);
        chk("addr_q_empty", 64'(addr_q.size()), 64'h0);
        chk("res_q_empty", 64'(res_q.size()), 64'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

endmodule
